// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid buffer. in_ready is decoded from
// registered state only, so upstream never sees a combinational path from
// out_ready or stall. Flush discards everything and counts lossy flushes.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no valid entry, out_data holds NOP_VAL or stale main
// ST_ONE   | main valid, skid free
// ST_FULL  | main and skid valid, input blocked
module pipe_skid_reg #(
   parameter int             WIDTH   = 64,
   parameter logic [WIDTH-1:0] NOP_VAL = '0,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stall,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] flush_drops
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   main_q, main_d;
   logic [WIDTH-1:0]   skid_q, skid_d;
   logic [CNT_W-1:0]   drops_q, drops_d;
   logic               in_fire;
   logic               out_fire;

   assign in_ready    = (state_q != ST_FULL);
   assign out_valid   = (state_q != ST_EMPTY);
   assign out_data    = main_q;
   assign flush_drops = drops_q;
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready & ~stall;

   // Occupancy decoded explicitly so it does not depend on the enum encoding.
   always_comb begin
      occupancy = 2'd0;
      case (state_q)
         ST_ONE:  occupancy = 2'd1;
         ST_FULL: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Next-state and datapath; flush takes priority over every handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      drops_d = drops_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = NOP_VAL;
         skid_d  = NOP_VAL;
         // Only lossy flushes count, and the counter sticks at all-ones.
         if (state_q != ST_EMPTY && drops_q != {CNT_W{1'b1}}) begin
            drops_d = drops_q + 1'b1;
         end
      end
   end

   // State register with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         main_q  <= NOP_VAL;
         skid_q  <= NOP_VAL;
         drops_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         drops_q <= drops_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, backpressure, stall,
// flush collision, counter saturation and reset in the middle of traffic.
module tb_pipe_skid_reg;

   localparam int             WIDTH = 64;
   localparam int             CNT_W = 2;
   localparam logic [63:0]    NOP   = 64'hDEAD_0000_0000_BEEF;
   localparam logic [63:0]    DA    = 64'hA5A5_1234_5678_9ABC;
   localparam logic [63:0]    DB    = 64'h0F0F_FEDC_BA98_7654;
   localparam logic [63:0]    DC    = 64'hCCCC_0000_FFFF_3333;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             stall;
   logic             flush;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] flush_drops;

   int vectors = 0;
   int miscompares = 0;

   pipe_skid_reg #(.WIDTH(WIDTH), .NOP_VAL(NOP), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .stall       (stall),
      .flush       (flush),
      .occupancy   (occupancy),
      .flush_drops (flush_drops)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_ab();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DA;
      tick();
      in_data   = DB;
      tick();
      in_valid  = 1'b0;
      chk("load_occ", 64'(occupancy), 64'd2);
      chk("load_in_ready", 64'(in_ready), 64'd0);
      chk("load_head", out_data, DA);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      stall = 1'b0; flush = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_out_data", out_data, NOP);
      chk("rst_drops", 64'(flush_drops), 64'd0);

      // Streaming 1..10 at full rate.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_data = 64'(i);
         tick();
         chk("stream_data", out_data, 64'(i));
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain_occ", 64'(occupancy), 64'd0);
      chk("stream_drain_valid", 64'(out_valid), 64'd0);

      // Backpressure: A and B buffered, then drained in order.
      load_ab();
      out_ready = 1'b1;
      tick();
      chk("bp_second", out_data, DB);
      chk("bp_second_occ", 64'(occupancy), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("bp_empty_occ", 64'(occupancy), 64'd0);

      // Stall holds A while FULL despite out_ready.
      load_ab();
      out_ready = 1'b1;
      stall     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold_data", out_data, DA);
         chk("stall_hold_occ", 64'(occupancy), 64'd2);
      end
      stall = 1'b0;
      tick();
      chk("stall_release_b", out_data, DB);
      tick();
      chk("stall_release_occ", 64'(occupancy), 64'd0);

      // Flush in FULL collides with a new input C.
      load_ab();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = DC;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_out_data", out_data, NOP);
      chk("flush_drops", 64'(flush_drops), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("flush_no_c_valid", 64'(out_valid), 64'd0);
      chk("flush_no_c_data", out_data, NOP);

      // Saturation of the 2-bit drop counter, with EMPTY flushes in between.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("sat_reset", 64'(flush_drops), 64'd0);
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = 64'(100 + i);
         tick();
         in_valid = 1'b0;
         chk("sat_loaded_data", out_data, 64'(100 + i));
         flush = 1'b1;
         tick();
         flush = 1'b0;
         chk("sat_drops", 64'(flush_drops), (i < 3) ? 64'(i) : 64'd3);
         if (i == 1) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("sat_empty_flush_low", 64'(flush_drops), 64'd1);
         end
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_empty_flush", 64'(flush_drops), 64'd3);

      // Reset arriving in FULL together with flush.
      load_ab();
      rst   = 1'b0;
      flush = 1'b1;
      tick();
      rst   = 1'b1;
      flush = 1'b0;
      chk("midrst_occ", 64'(occupancy), 64'd0);
      chk("midrst_drops", 64'(flush_drops), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_data", out_data, NOP);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning payload width in bits (for example {PC, instruction}).
REQ-002 The block SHALL have parameter NOP_VAL, default 0 (WIDTH bits), meaning the payload value loaded on reset and on flush.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the flush-drop counter.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream payload is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a payload this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the entry.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the head entry.
REQ-012 The block SHALL have port stall, input, 1 bit: a hazard hold that blocks output transfer.
REQ-013 The block SHALL have port flush, input, 1 bit: discards all entries (branch or exception).
REQ-014 The block SHALL have port occupancy, output, 2 bits: the number of valid entries (0..2).
REQ-015 The block SHALL have port flush_drops, output, CNT_W bits: a saturating count of flushes that discarded at least one valid entry.

Function
REQ-016 Storage SHALL be a main register (drives out_data) plus one skid register, with state EMPTY (0 entries), ONE (main valid) or FULL (main and skid valid).
REQ-017 in_fire SHALL be defined as in_valid & in_ready; out_fire SHALL be defined as out_valid & out_ready & ~stall.
REQ-018 in_ready SHALL be 1 exactly when state is not FULL, decoded from registered state only with no combinational path from out_ready or stall.
REQ-019 out_valid SHALL be 1 exactly when state is not EMPTY; occupancy SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-020 In EMPTY, in_fire SHALL load main with in_data and go to ONE; otherwise EMPTY SHALL hold.
REQ-021 In ONE, in_fire with out_fire SHALL load main with in_data and stay in ONE.
REQ-022 In ONE, in_fire without out_fire SHALL load skid with in_data and go to FULL.
REQ-023 In ONE, out_fire without in_fire SHALL go to EMPTY with main unchanged; with neither event, ONE SHALL hold.
REQ-024 In FULL, out_fire SHALL copy skid into main and go to ONE; otherwise FULL SHALL hold (in_ready is 0, so there is no input).
REQ-025 Latency SHALL be 1 cycle from in_fire to out_valid when the block is EMPTY; throughput SHALL be 1 entry per cycle with out_ready=1 and stall=0.
REQ-026 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or lost except by flush.
REQ-027 While stall=1, state, main and skid SHALL change only through acceptance of input (ONE->FULL, EMPTY->ONE), and out_data SHALL stay constant while out_valid=1.
REQ-028 A flush SHALL, on the next edge, set the state to EMPTY and load main and skid with NOP_VAL.
REQ-029 Flush SHALL override a simultaneous in_fire (that payload is discarded) and a simultaneous out_fire or stall.
REQ-030 A flush SHALL increment flush_drops by 1 when occupancy is nonzero before the edge; flush_drops SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 A flush in EMPTY SHALL leave flush_drops unchanged.
REQ-032 Payload values SHALL pass through bit-exact at any WIDTH of 1 or more.

Reset
REQ-033 With rst=0 at a clock edge, the state SHALL become EMPTY, main and skid SHALL become NOP_VAL, and flush_drops SHALL become 0.
REQ-034 Reset SHALL override flush, stall and all handshakes, including when it arrives mid-operation in FULL.
REQ-035 Immediately after reset, outputs SHALL be out_valid=0, in_ready=1, occupancy=0 and out_data=NOP_VAL.

Verification
REQ-036 Streaming: WIDTH=64, drive in_valid=1 with data 1,2,3,...,10, out_ready=1, stall=0 -> out_data equals 1..10 on consecutive cycles, starting 1 cycle after the first in_fire, with occupancy constantly 1.
REQ-037 Backpressure: load A and B with out_ready=0 -> occupancy=2 and in_ready=0; raise out_ready -> A then B on consecutive cycles, then occupancy=0.
REQ-038 Stall: FULL with out_ready=1 and stall=1 for 3 cycles -> out_data holds A for those 3 cycles; drop stall -> A then B emitted.
REQ-039 Flush collision: in FULL, assert flush together with in_valid=1 (data C) -> next cycle occupancy=0, out_data=NOP_VAL and flush_drops=1; C never appears at the output.
REQ-040 Saturation: CNT_W=2, perform 5 flushes each with occupancy 1 plus one flush in EMPTY -> flush_drops reads 1,2,3,3,3 and is unchanged by the EMPTY flush.
REQ-041 Reset mid-operation: assert rst=0 in FULL with flush=1 -> next cycle EMPTY, flush_drops=0 and in_ready=1.
